keypad_scan_tx: RTL and testbench
=================================

Name: keypad_scan_tx

Overview:
- Scans the 4x4 calculator keypad matrix and debounces key presses.
- Emits the 8-bit key-code stream plus the pressed level consumed by the calculator FSM. This block is the producing end of the in/pressed interface.
- The calculator clocks its state register on the falling edge of pressed, so pressed must be glitch-free and registered.
- key_code must remain stable from the rise of pressed until after pressed falls.

Parameters:
- SCAN_DIV, 1000: clk cycles each column is driven before advancing (>=2).
- DEBOUNCE_CNT, 200000: consecutive stable synchronised samples required to accept a press or a release (>=2).

Ports:
- clk  input  1  system clock
- rst  input  1  reset: asynchronous, active-high
- row_n  input  4  keypad rows, active-low, externally pulled up, asynchronous
- col_n  output  4  column drive, one-hot active-low
- key_code  output  8  code of the last accepted key; held until the next accepted key
- key_valid  output  1  one-cycle strobe when a new key is accepted
- pressed  output  1  high from key acceptance until debounced release

Behaviour:
- Reset values: col_n=4'b1110, key_code=8'hFF (idle, all ones), key_valid=0, pressed=0, state=SCAN, all counters 0. Reset mid-operation aborts immediately to these values.
- Row synchronisation:
  - row_n passes through a 2-FF synchroniser; all logic uses the synced value rs.
  - Every latency below counts from rs.
- Key map, with rows r0..r3 and columns c0..c3:
  - r0: 1, 2, 3, +
  - r1: 4, 5, 6, -
  - r2: 7, 8, 9, *
  - r3: C, 0, =, /
- Codes:
  - Digits d map to 8'h0d (bit7=0).
  - Operators: + 8'h80, - 8'h81, * 8'h82, / 8'h83, C 8'h8E, = 8'h8F. All operators have bit7=1.
- SCAN state:
  - Drive column c low.
  - Scan timer counts 0..SCAN_DIV-1; rs is sampled only when timer=SCAN_DIV-1 (settled).
  - If the sample is 4'b1111, advance c (wrap 3->0) and reset the timer.
  - Otherwise latch pat=rs, freeze the column, clear the debounce counter, and go to DEBOUNCE.
- DEBOUNCE state:
  - Each cycle, if rs==pat, increment the counter. Otherwise reset the counter to 0 and set pat=rs.
  - If the new rs is 4'b1111, return to SCAN on the same column with the timer reset.
  - When the counter reaches DEBOUNCE_CNT:
    - If pat has exactly one zero: register key_code, pulse key_valid=1, set pressed=1, go to HELD. key_code and pressed update in the same cycle.
    - If pat has multiple zeros (multi-key): emit nothing and go to RELEASE_DB, with pressed remaining 0.
- HELD state:
  - Column frozen.
  - Stays while rs != 4'b1111.
  - On rs==4'b1111, clear the counter and go to RELEASE_DB.
- RELEASE_DB state:
  - Counts consecutive cycles of rs==4'b1111.
  - Any low row resets the counter. If pressed=1, return to HELD with no new key_valid; if pressed=0 (multi-key case), stay in RELEASE_DB.
  - At DEBOUNCE_CNT: set pressed=0, advance the column, reset the timer, go to SCAN.
  - key_code is unchanged.
- Latency: with the first low sample at SCAN cycle t, key_valid and pressed assert at cycle t+DEBOUNCE_CNT+1 if there is no bounce.
- key_valid only ever pulses in the DEBOUNCE->HELD transition, at most once per physical press.
- Second key pressed while HELD: ignored. Only the frozen column is observed, and a change in pattern does not retrigger.
- Counter widths are $clog2(param)+1; counters never wrap.

Decomposition:
- Shared header calc_keys: key-code constants (KEY_ADD, KEY_SUB, KEY_MUL, KEY_DIV, KEY_CLR, KEY_EQ=8'h8F, KEY_IDLE=8'hFF) and state encodings. The calculator FSM includes the same header.
- One sub-module, keypad_row_sync: 4-bit 2-FF synchroniser with async reset to 4'b1111.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=8):
1. Reset: assert rst mid-DEBOUNCE -> col_n=1110, key_code=FF, pressed=0, key_valid=0 immediately.
2. Clean press of r1c1 ("5") held 30 cycles, then released -> one key_valid pulse, key_code=8'h05, pressed high, then low 8+ cycles after release; key_code stays 05.
3. Bounced press of "=" (r3c2: 3 toggles within 5 cycles, then stable) -> exactly one key_valid, key_code=8'h8F. A 3-cycle release glitch while HELD -> pressed stays 1, no new strobe.
4. Sequence "1","2","+","3","4","=" -> codes 01, 02, 80, 03, 04, 8F in order; six falling edges of pressed.
5. r0 and r1 low simultaneously in c0 -> no key_valid, pressed=0; scanning resumes only after full release.
6. Column wrap: no key for 20 cycles -> col_n sequence 1110, 1101, 1011, 0111, 1110, each held 4 cycles.

Source files
------------

// File: rtl/keypad_scan_tx_pkg.sv
// Key-code constants, scanner state encoding and key-map helpers shared with
// the calculator FSM.
package keypad_scan_tx_pkg;

  localparam logic [7:0] KEY_ADD  = 8'h80;
  localparam logic [7:0] KEY_SUB  = 8'h81;
  localparam logic [7:0] KEY_MUL  = 8'h82;
  localparam logic [7:0] KEY_DIV  = 8'h83;
  localparam logic [7:0] KEY_CLR  = 8'h8E;
  localparam logic [7:0] KEY_EQ   = 8'h8F;
  localparam logic [7:0] KEY_IDLE = 8'hFF;

  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    DEBOUNCE   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } kp_state_e;

  function automatic logic [7:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [7:0] code;
    code = KEY_IDLE;
    case ({row, col})
      4'h0: code = 8'h01;
      4'h1: code = 8'h02;
      4'h2: code = 8'h03;
      4'h3: code = KEY_ADD;
      4'h4: code = 8'h04;
      4'h5: code = 8'h05;
      4'h6: code = 8'h06;
      4'h7: code = KEY_SUB;
      4'h8: code = 8'h07;
      4'h9: code = 8'h08;
      4'hA: code = 8'h09;
      4'hB: code = KEY_MUL;
      4'hC: code = KEY_CLR;
      4'hD: code = 8'h00;
      4'hE: code = KEY_EQ;
      4'hF: code = KEY_DIV;
      default: code = KEY_IDLE;
    endcase
    return code;
  endfunction

  function automatic logic single_low(input logic [3:0] p);
    return ($countones(~p) == 1);
  endfunction

  function automatic logic [1:0] low_row(input logic [3:0] p);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (!p[i]) r = 2'(i);
    return r;
  endfunction

endpackage

// File: rtl/keypad_scan_tx_if.sv
// Keypad matrix lines plus the key-code / pressed stream to the calculator.
interface keypad_scan_tx_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [7:0] key_code;
  logic       key_valid;
  logic       pressed;

  modport master (input row_n, output col_n, key_code, key_valid, pressed);
  modport slave  (output row_n, input col_n, key_code, key_valid, pressed);
endinterface

// File: rtl/keypad_row_sync.sv
// Two-flop synchroniser for the asynchronous keypad rows; idles released.
module keypad_row_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] row_n,
  output logic [W-1:0] rs
);
  logic [1:0][W-1:0] sync_pipe;

  always_ff @(posedge clk or posedge rst)
    if (rst) sync_pipe <= '1;
    else     sync_pipe <= {sync_pipe[0], row_n};

  assign rs = sync_pipe[1];
endmodule

// File: rtl/keypad_scan_tx.sv
// 4x4 keypad scanner: column scan, press/release debounce, key-code encode.
// All outputs come straight from flops so pressed is glitch-free.
module keypad_scan_tx
  import keypad_scan_tx_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 200000
) (
  input  logic             clk,
  input  logic             rst,
  keypad_scan_tx_if.master kp
);
  localparam int TW = $clog2(SCAN_DIV) + 1;
  localparam int CW = $clog2(DEBOUNCE_CNT) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CNT - 1);

  kp_state_e     state_q, state_d;
  logic [1:0]    col_q, col_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    pat_q, pat_d;
  logic [7:0]    code_q, code_d;
  logic          kv_q, kv_d;
  logic          prs_q, prs_d;
  logic [3:0]    rs;

  keypad_row_sync #(.W(4)) u_sync (
    .clk   (clk),
    .rst   (rst),
    .row_n (kp.row_n),
    .rs    (rs)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= SCAN;
      col_q   <= 2'd0;
      tmr_q   <= '0;
      cnt_q   <= '0;
      pat_q   <= ROWS_IDLE;
      code_q  <= KEY_IDLE;
      kv_q    <= 1'b0;
      prs_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      code_q  <= code_d;
      kv_q    <= kv_d;
      prs_q   <= prs_d;
    end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    code_d  = code_q;
    kv_d    = 1'b0;
    prs_d   = prs_q;
    case (state_q)
      SCAN: begin
        // rows are only trusted once the column drive has settled
        if (tmr_q == T_LAST) begin
          tmr_d = '0;
          if (rs == ROWS_IDLE) begin
            col_d = col_q + 2'd1;
          end else begin
            pat_d   = rs;
            cnt_d   = '0;
            state_d = DEBOUNCE;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (rs != pat_q) begin
          cnt_d = '0;
          pat_d = rs;
          if (rs == ROWS_IDLE) begin
            tmr_d   = '0;
            state_d = SCAN;
          end
        end else if (cnt_q == C_LAST) begin
          cnt_d = '0;
          // multi-key chords are swallowed; wait for a clean release
          if (single_low(pat_q)) begin
            code_d  = key_lookup(low_row(pat_q), col_q);
            kv_d    = 1'b1;
            prs_d   = 1'b1;
            state_d = HELD;
          end else begin
            state_d = RELEASE_DB;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (rs == ROWS_IDLE) begin
          cnt_d   = '0;
          state_d = RELEASE_DB;
        end
      end
      RELEASE_DB: begin
        if (rs != ROWS_IDLE) begin
          cnt_d = '0;
          if (prs_q) state_d = HELD;
        end else if (cnt_q == C_LAST) begin
          cnt_d   = '0;
          prs_d   = 1'b0;
          col_d   = col_q + 2'd1;
          tmr_d   = '0;
          state_d = SCAN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  assign kp.col_n     = ~(4'b0001 << col_q);
  assign kp.key_code  = code_q;
  assign kp.key_valid = kv_q;
  assign kp.pressed   = prs_q;

endmodule

// File: tb/tb_keypad_scan_tx.sv
// Bench: behavioural keypad matrix driving the scanner, checked against the
// textual key map and press/release timing rules.
module tb_keypad_scan_tx;
  localparam int SD = 4;
  localparam int DB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_scan_tx_if kif();

  // physical switches, [row][col]
  logic [3:0][3:0] key_dn = '0;

  always_comb begin
    kif.row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      if (|(key_dn[r] & ~kif.col_n)) kif.row_n[r] = 1'b0;
  end

  keypad_scan_tx #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kif)
  );

  int checks = 0;
  int errors = 0;
  int kv_cnt = 0;
  int fall_cnt = 0;
  int viol = 0;
  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];
  logic       prev_p = 1'b0;
  logic       prev_kv = 1'b0;
  logic [7:0] prev_code = 8'hFF;

  // protocol monitor: strobe count, codes, and stability of key_code while pressed
  always @(posedge clk) begin
    if (kif.key_valid === 1'b1) begin
      kv_cnt <= kv_cnt + 1;
      obs_q.push_back(kif.key_code);
    end
    if (!rst) begin
      if (prev_p && !kif.pressed) fall_cnt <= fall_cnt + 1;
      if ((prev_p && kif.pressed && kif.key_code !== prev_code) ||
          (!prev_p && kif.pressed && !kif.key_valid) ||
          (kif.key_valid && !kif.pressed) ||
          (prev_kv && kif.key_valid))
        viol <= viol + 1;
    end
    prev_p    <= kif.pressed;
    prev_kv   <= kif.key_valid;
    prev_code <= kif.key_code;
  end

  function automatic logic [7:0] ref_code(input int r, input int c);
    string rows[4];
    byte   ch;
    rows = '{"123+", "456-", "789*", "C0=/"};
    ch = rows[r][c];
    if (ch >= "0" && ch <= "9") return 8'(ch - "0");
    case (ch)
      "+": return 8'h80;
      "-": return 8'h81;
      "*": return 8'h82;
      "/": return 8'h83;
      "C": return 8'h8E;
      "=": return 8'h8F;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rise(input string tag, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (kif.pressed !== 1'b1 && n < 100);
    chk({tag, " rise"}, kif.pressed, 1);
  endtask

  task automatic wait_fall(input string tag, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (kif.pressed !== 1'b0 && n < 100);
    chk({tag, " fall"}, kif.pressed, 0);
  endtask

  task automatic press_release(input int r, input int c, input int extra, input string tag);
    int n, kv0, f0;
    logic [7:0] e;
    e   = ref_code(r, c);
    exp_q.push_back(e);
    kv0 = kv_cnt;
    f0  = fall_cnt;
    key_dn[r][c] = 1'b1;
    wait_rise(tag, n);
    chk({tag, " lat_min"}, n >= DB + 3, 1);
    chk({tag, " code"}, kif.key_code, e);
    chk({tag, " strobe"}, kif.key_valid, 1);
    repeat (extra) @(negedge clk);
    key_dn[r][c] = 1'b0;
    wait_fall(tag, n);
    chk({tag, " rel_lat"}, (n >= DB + 2) && (n <= DB + 4), 1);
    chk({tag, " code_hold"}, kif.key_code, e);
    @(negedge clk);
    chk({tag, " one_strobe"}, kv_cnt - kv0, 1);
    chk({tag, " one_fall"}, fall_cnt - f0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, kv0, f0, stable;
    logic allp;
    int seq_r[6];
    int seq_c[6];
    seq_r = '{0, 0, 0, 0, 1, 3};
    seq_c = '{0, 1, 3, 2, 0, 2};

    // reset values and idle column rotation
    repeat (3) @(negedge clk);
    chk("rst col_n", kif.col_n, 4'b1110);
    chk("rst key_code", kif.key_code, 8'hFF);
    chk("rst key_valid", kif.key_valid, 0);
    chk("rst pressed", kif.pressed, 0);
    rst = 1'b0;
    #1;
    chk("wrap k0", kif.col_n, 4'b1110);
    for (int k = 1; k < 20; k++) begin
      logic [3:0] ec;
      @(negedge clk);
      ec = ~(4'b0001 << ((k / SD) % 4));
      chk($sformatf("wrap k%0d", k), kif.col_n, ec);
    end

    // clean press of "5" held ~30 cycles
    press_release(1, 1, 15, "five");

    // reset while debouncing "6": must abort to idle values at once
    key_dn[1][2] = 1'b1;
    stable = 0;
    n = 0;
    while (stable < SD + 2 && n < 60) begin
      @(negedge clk);
      n++;
      if (kif.col_n == 4'b1011) stable++; else stable = 0;
    end
    chk("mid_db frozen", kif.col_n, 4'b1011);
    chk("mid_db pressed", kif.pressed, 0);
    chk("mid_db code", kif.key_code, 8'h05);
    #2 rst = 1'b1;
    #1;
    chk("async col_n", kif.col_n, 4'b1110);
    chk("async key_code", kif.key_code, 8'hFF);
    chk("async pressed", kif.pressed, 0);
    chk("async key_valid", kif.key_valid, 0);
    key_dn = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // bounced "=" then short release glitch while held
    kv0 = kv_cnt;
    exp_q.push_back(ref_code(3, 2));
    key_dn[3][2] = 1'b1; @(negedge clk);
    key_dn[3][2] = 1'b0; @(negedge clk);
    key_dn[3][2] = 1'b1; @(negedge clk);
    key_dn[3][2] = 1'b0; @(negedge clk);
    key_dn[3][2] = 1'b1;
    wait_rise("bounce", n);
    chk("bounce code", kif.key_code, 8'h8F);
    repeat (5) @(negedge clk);
    key_dn[3][2] = 1'b0;
    repeat (3) @(negedge clk);
    key_dn[3][2] = 1'b1;
    allp = 1'b1;
    repeat (15) begin @(negedge clk); allp &= kif.pressed; end
    chk("glitch pressed", allp, 1);
    chk("glitch strobes", kv_cnt - kv0, 1);
    key_dn[3][2] = 1'b0;
    wait_fall("bounce", n);
    chk("bounce code_hold", kif.key_code, 8'h8F);
    repeat (2) @(negedge clk);

    // calculator sequence 1 2 + 3 4 =
    f0 = fall_cnt;
    for (int i = 0; i < 6; i++)
      press_release(seq_r[i], seq_c[i], 2, $sformatf("seq%0d", i));
    chk("seq falls", fall_cnt - f0, 6);

    // two rows in c0: chord is ignored until everything is released
    kv0 = kv_cnt;
    key_dn[0][0] = 1'b1;
    key_dn[1][0] = 1'b1;
    repeat (40) @(negedge clk);
    chk("multi pressed", kif.pressed, 0);
    chk("multi frozen", kif.col_n, 4'b1110);
    key_dn[1][0] = 1'b0;
    repeat (20) @(negedge clk);
    chk("multi partial col", kif.col_n, 4'b1110);
    chk("multi partial pressed", kif.pressed, 0);
    key_dn[0][0] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (kif.col_n == 4'b1110 && n < 30);
    chk("multi resume col", kif.col_n, 4'b1101);
    chk("multi strobes", kv_cnt - kv0, 0);

    // randomized key sequence
    for (int i = 0; i < 8; i++) begin
      int rr, cc;
      rr = int'($urandom_range(0, 3));
      cc = int'($urandom_range(0, 3));
      press_release(rr, cc, int'($urandom_range(0, 15)), $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 10)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    chk("code count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("code stream %0d", i), obs_q[i], exp_q[i]);
    chk("protocol", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
